// File: rtl/gf180mcu_fd_sc_mcu7t5v0__rrarb4.sv
// -----------------------------------------------------------------------------
// gf180mcu_fd_sc_mcu7t5v0__rrarb4
//
// Four-requester round-robin arbiter. A registered one-hot grant is issued
// from IDLE to the first requester found scanning from the priority pointer.
// The grant is held until the owner pulses DONE or withdraws its request.
// On release the pointer moves to the slot after the last owner, and one IDLE
// turnaround cycle always separates two grants.
//
// Optional feature (macro GF180MCU_FD_SC_MCU7T5V0__RRARB4_TIMEOUT_EN):
//   an 8-bit hold counter revokes a grant after HOLD_MAX cycles of tenure and
//   pulses TOUT for the IDLE cycle that follows. Without the macro TOUT is 0
//   and HOLD_MAX has no effect.
//
// Parameters:
//   HOLD_MAX  maximum grant tenure in cycles (1..255), timeout build only
// Ports:
//   CLK   in   rising-edge clock
//   RN    in   asynchronous active-low reset
//   REQ   in   [3:0] level-sensitive request, bit i = master i
//   DONE  in   release strobe from the current owner (sampled in GRANT)
//   GNT   out  [3:0] registered one-hot grant or zero
//   GID   out  [1:0] index of the current or last owner
//   BUSY  out  high while a grant is held
//   TOUT  out  one-cycle pulse after a forced release
// -----------------------------------------------------------------------------
module gf180mcu_fd_sc_mcu7t5v0__rrarb4 #(
    parameter int HOLD_MAX = 15
) (
    input  logic       CLK,
    input  logic       RN,
    input  logic [3:0] REQ,
    input  logic       DONE,
    output logic [3:0] GNT,
    output logic [1:0] GID,
    output logic       BUSY,
    output logic       TOUT
);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    state_t     r_state;
    state_t     w_state_next;
    logic [3:0] r_gnt;
    logic [3:0] w_gnt_next;
    logic [1:0] r_gid;
    logic [1:0] w_gid_next;
    logic [1:0] r_ptr;
    logic [1:0] w_ptr_next;
    logic       r_busy;
    logic       w_busy_next;

    logic [3:0] w_hit;         // requests rotated so that bit 0 is slot PTR
    logic [1:0] w_off;         // offset of the winner from PTR
    logic [1:0] w_win;         // absolute winner index
    logic [3:0] w_win_onehot;
    logic       w_owner_req;
    logic       w_timeout;
    logic       w_release;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_rot
            assign w_hit[gi]        = REQ[r_ptr + 2'(gi)];
            assign w_win_onehot[gi] = (w_win == 2'(gi));
        end
    endgenerate

    // Lowest rotated position wins, i.e. nearest to PTR in scan order.
    always_comb begin
        w_off = 2'd0;
        if (w_hit[0])      w_off = 2'd0;
        else if (w_hit[1]) w_off = 2'd1;
        else if (w_hit[2]) w_off = 2'd2;
        else if (w_hit[3]) w_off = 2'd3;
    end

    assign w_win       = r_ptr + w_off;
    assign w_owner_req = REQ[r_gid];
    assign w_release   = DONE | ~w_owner_req | w_timeout;

`ifdef GF180MCU_FD_SC_MCU7T5V0__RRARB4_TIMEOUT_EN
    logic [7:0] r_cnt;
    logic [7:0] w_cnt_next;
    logic       r_tout;
    logic       w_tout_next;

    assign w_timeout = (r_state == ST_GRANT) && (r_cnt == 8'(HOLD_MAX - 1));

    // A timeout coinciding with DONE or an owner drop is an ordinary release.
    assign w_tout_next = w_timeout & ~DONE & w_owner_req;

    always_comb begin
        w_cnt_next = 8'd0;
        if (r_state == ST_GRANT && !w_release)
            w_cnt_next = r_cnt + 8'd1;
    end

    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            r_cnt  <= 8'd0;
            r_tout <= 1'b0;
        end else begin
            r_cnt  <= w_cnt_next;
            r_tout <= w_tout_next;
        end
    end

    assign TOUT = r_tout;
`else
    logic w_unused_hold;

    assign w_timeout     = 1'b0;
    assign w_unused_hold = (HOLD_MAX > 0);
    assign TOUT          = 1'b0;
`endif

    always_comb begin
        w_state_next = r_state;
        w_gnt_next   = r_gnt;
        w_gid_next   = r_gid;
        w_ptr_next   = r_ptr;
        w_busy_next  = r_busy;
        case (r_state)
            ST_IDLE: begin
                if (|REQ) begin
                    w_state_next = ST_GRANT;
                    w_gnt_next   = w_win_onehot;
                    w_gid_next   = w_win;
                    w_busy_next  = 1'b1;
                end
            end
            ST_GRANT: begin
                // Release always lands in IDLE so grants never hop owners.
                if (w_release) begin
                    w_state_next = ST_IDLE;
                    w_gnt_next   = 4'b0000;
                    w_busy_next  = 1'b0;
                    w_ptr_next   = r_gid + 2'd1;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
                w_gnt_next   = 4'b0000;
                w_busy_next  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            r_state <= ST_IDLE;
            r_gnt   <= 4'b0000;
            r_gid   <= 2'd0;
            r_ptr   <= 2'd0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_gnt   <= w_gnt_next;
            r_gid   <= w_gid_next;
            r_ptr   <= w_ptr_next;
            r_busy  <= w_busy_next;
        end
    end

    assign GNT  = r_gnt;
    assign GID  = r_gid;
    assign BUSY = r_busy;

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu7t5v0__rrarb4.sv
// -----------------------------------------------------------------------------
// Directed testbench for the four-requester round-robin arbiter.
// Each comparison checks the packed observation {GNT, GID, BUSY, TOUT}
// against a hand-computed 8-bit value.
// -----------------------------------------------------------------------------
module tb_gf180mcu_fd_sc_mcu7t5v0__rrarb4;

    logic       CLK = 1'b0;
    logic       RN;
    logic [3:0] REQ;
    logic       DONE;
    logic [3:0] GNT;
    logic [1:0] GID;
    logic       BUSY;
    logic       TOUT;

    int checks   = 0;
    int failures = 0;

    gf180mcu_fd_sc_mcu7t5v0__rrarb4 #(
        .HOLD_MAX(4)
    ) dut (
        .CLK (CLK),
        .RN  (RN),
        .REQ (REQ),
        .DONE(DONE),
        .GNT (GNT),
        .GID (GID),
        .BUSY(BUSY),
        .TOUT(TOUT)
    );

    always #5 CLK = ~CLK;

    // Advance one clock; outputs are then sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        logic [7:0] obs;
        RN   = 1'b0;
        REQ  = 4'b0000;
        DONE = 1'b0;
        tick();
        tick();
        obs = {GNT, GID, BUSY, TOUT};
        checks++;
        if (obs !== 8'b0000_00_0_0) begin
            failures++;
            $display("FAIL reset_held obs=%b expected=%b", obs, 8'b0000_00_0_0);
        end
        RN = 1'b1;
        // Get a grant to master 2, then reset asynchronously mid-cycle.
        REQ = 4'b0100;
        tick();
        obs = {GNT, GID, BUSY, TOUT};
        checks++;
        if (obs !== 8'b0100_10_1_0) begin
            failures++;
            $display("FAIL reset_pregrant obs=%b expected=%b", obs, 8'b0100_10_1_0);
        end
        #1 RN = 1'b0;
        #1;
        obs = {GNT, GID, BUSY, TOUT};
        checks++;
        if (obs !== 8'b0000_00_0_0) begin
            failures++;
            $display("FAIL reset_async obs=%b expected=%b", obs, 8'b0000_00_0_0);
        end
        REQ = 4'b0000;
        #1 RN = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            obs = {GNT, GID, BUSY, TOUT};
            checks++;
            if (obs !== 8'b0000_00_0_0) begin
                failures++;
                $display("FAIL reset_idle cycle=%0d obs=%b expected=%b", i, obs, 8'b0000_00_0_0);
            end
        end
    endtask

    // PTR=0 on entry. Ends with PTR=1, GID=0.
    task automatic test_rotation();
        logic [7:0] obs;
        logic [7:0] exp_tab [5];
        exp_tab[0] = 8'b0001_00_1_0;
        exp_tab[1] = 8'b0010_01_1_0;
        exp_tab[2] = 8'b0100_10_1_0;
        exp_tab[3] = 8'b1000_11_1_0;
        exp_tab[4] = 8'b0001_00_1_0;
        REQ  = 4'b1111;
        DONE = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            obs = {GNT, GID, BUSY, TOUT};
            checks++;
            if (obs !== exp_tab[i]) begin
                failures++;
                $display("FAIL rotation_grant idx=%0d obs=%b expected=%b", i, obs, exp_tab[i]);
            end
            DONE = 1'b1;
            tick();
            DONE = 1'b0;
            obs = {GNT, GID, BUSY, TOUT};
            checks++;
            if (obs !== {4'b0000, exp_tab[i][3:2], 2'b00}) begin
                failures++;
                $display("FAIL rotation_idle idx=%0d obs=%b expected=%b", i, obs,
                         {4'b0000, exp_tab[i][3:2], 2'b00});
            end
        end
    endtask

    // PTR=1 on entry. Master 3 owns then releases; PTR must wrap to 0.
    task automatic test_wrap();
        logic [7:0] obs;
        REQ = 4'b1000;
        tick();
        obs = {GNT, GID, BUSY, TOUT};
        checks++;
        if (obs !== 8'b1000_11_1_0) begin
            failures++;
            $display("FAIL wrap_m3 obs=%b expected=%b", obs, 8'b1000_11_1_0);
        end
        DONE = 1'b1;
        tick();
        DONE = 1'b0;
        REQ  = 4'b1001;
        tick();
        obs = {GNT, GID, BUSY, TOUT};
        checks++;
        if (obs !== 8'b0001_00_1_0) begin
            failures++;
            $display("FAIL wrap_next obs=%b expected=%b", obs, 8'b0001_00_1_0);
        end
        DONE = 1'b1;
        tick();
        DONE = 1'b0;
        REQ  = 4'b0000;
        tick();
    endtask

    // PTR=1 on entry. Ends with PTR=0 after master 3 releases.
    task automatic test_owner_drop();
        logic [7:0] obs;
        REQ = 4'b0010;
        tick();
        for (int i = 0; i < 5; i++) begin
            REQ[3] = (i % 2 == 0);
            REQ[0] = (i % 2 != 0);
            tick();
            obs = {GNT, GID, BUSY, TOUT};
            checks++;
            if (obs !== 8'b0010_01_1_0) begin
                failures++;
                $display("FAIL drop_mask cycle=%0d obs=%b expected=%b", i, obs, 8'b0010_01_1_0);
            end
        end
        REQ = 4'b1001;
        DONE = 1'b0;
        REQ[1] = 1'b0;
        tick();
        obs = {GNT, GID, BUSY, TOUT};
        checks++;
        if (obs !== 8'b0000_01_0_0) begin
            failures++;
            $display("FAIL drop_release obs=%b expected=%b", obs, 8'b0000_01_0_0);
        end
        // PTR=2: scan 2,3,0,1 with bit2 clear selects master 3.
        REQ = 4'b1011;
        tick();
        obs = {GNT, GID, BUSY, TOUT};
        checks++;
        if (obs !== 8'b1000_11_1_0) begin
            failures++;
            $display("FAIL drop_ptr obs=%b expected=%b", obs, 8'b1000_11_1_0);
        end
        DONE = 1'b1;
        tick();
        DONE = 1'b0;
        REQ  = 4'b0000;
        tick();
    endtask

`ifdef GF180MCU_FD_SC_MCU7T5V0__RRARB4_TIMEOUT_EN
    // HOLD_MAX=4, PTR=0 on entry.
    task automatic test_timeout();
        logic [7:0] obs;
        REQ = 4'b0100;
        for (int i = 0; i < 4; i++) begin
            tick();
            obs = {GNT, GID, BUSY, TOUT};
            checks++;
            if (obs !== 8'b0100_10_1_0) begin
                failures++;
                $display("FAIL tout_hold cycle=%0d obs=%b expected=%b", i, obs, 8'b0100_10_1_0);
            end
        end
        tick();
        obs = {GNT, GID, BUSY, TOUT};
        checks++;
        if (obs !== 8'b0000_10_0_1) begin
            failures++;
            $display("FAIL tout_forced obs=%b expected=%b", obs, 8'b0000_10_0_1);
        end
        REQ = 4'b0000;
        tick();
        obs = {GNT, GID, BUSY, TOUT};
        checks++;
        if (obs !== 8'b0000_10_0_0) begin
            failures++;
            $display("FAIL tout_pulse_end obs=%b expected=%b", obs, 8'b0000_10_0_0);
        end
        // DONE on the 4th cycle wins over the timeout.
        REQ = 4'b0100;
        for (int i = 0; i < 4; i++) tick();
        DONE = 1'b1;
        tick();
        DONE = 1'b0;
        REQ  = 4'b0000;
        obs = {GNT, GID, BUSY, TOUT};
        checks++;
        if (obs !== 8'b0000_10_0_0) begin
            failures++;
            $display("FAIL tout_done obs=%b expected=%b", obs, 8'b0000_10_0_0);
        end
        // Owner drop on the 4th cycle also wins over the timeout.
        tick();
        REQ = 4'b0100;
        for (int i = 0; i < 4; i++) tick();
        REQ = 4'b0000;
        tick();
        obs = {GNT, GID, BUSY, TOUT};
        checks++;
        if (obs !== 8'b0000_10_0_0) begin
            failures++;
            $display("FAIL tout_drop obs=%b expected=%b", obs, 8'b0000_10_0_0);
        end
        tick();
    endtask
`else
    task automatic test_no_timeout();
        logic [7:0] obs;
        REQ = 4'b0100;
        tick();
        for (int i = 0; i < 300; i++) begin
            obs = {GNT, GID, BUSY, TOUT};
            checks++;
            if (obs !== 8'b0100_10_1_0) begin
                failures++;
                $display("FAIL hold_forever cycle=%0d obs=%b expected=%b", i, obs, 8'b0100_10_1_0);
            end
            tick();
        end
        DONE = 1'b1;
        tick();
        DONE = 1'b0;
        REQ  = 4'b0000;
        obs = {GNT, GID, BUSY, TOUT};
        checks++;
        if (obs !== 8'b0000_10_0_0) begin
            failures++;
            $display("FAIL hold_release obs=%b expected=%b", obs, 8'b0000_10_0_0);
        end
        tick();
    endtask
`endif

    initial begin
        test_reset();
        test_rotation();
        test_wrap();
        test_owner_drop();
`ifdef GF180MCU_FD_SC_MCU7T5V0__RRARB4_TIMEOUT_EN
        test_timeout();
`else
        test_no_timeout();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/gf180mcu_fd_sc_mcu7t5v0__rrarb4.md
# gf180mcu_fd_sc_mcu7t5v0__rrarb4

Four-requester round-robin arbiter that shares one downstream resource, such as a shared OAI/AOI-based datapath or bus segment, among four masters. It issues a registered one-hot grant, holds it until the owner releases, and rotates priority so no requester starves. An optional hold-timeout forcibly revokes a grant that is held too long. It is part of the mcu7t5v0 soft-macro set and is built only from library sequential and combinational primitives.

## Interface
Parameters:
- HOLD_MAX, 15: maximum grant tenure in cycles. Legal range is 1..255. Used only when the timeout is compiled in.

Ports:
- CLK  input  1  rising-edge clock.
- RN  input  1  asynchronous, active-low reset.
- REQ  input  4  request per master; bit i belongs to master i. Level-sensitive.
- DONE  input  1  release strobe from the current owner. Sampled only in GRANT.
- GNT  output  4  registered one-hot grant, or all zero.
- GID  output  2  binary index of the current or last owner. Registered.
- BUSY  output  1  high while in GRANT, equal to the OR of GNT.
- TOUT  output  1  one-cycle pulse reporting a forced release.

## Operation
- Asserting RN low forces, asynchronously: state IDLE, GNT=0000, GID=00, BUSY=0, TOUT=0, priority pointer PTR=0, hold counter=0.
- States:
  - IDLE: no grant.
  - GRANT: one master owns the resource.
- IDLE → GRANT at a rising edge where REQ≠0.
  - Winner is the first asserted bit scanning PTR, PTR+1, PTR+2, PTR+3, all mod 4.
  - GNT[winner]=1, GID=winner, BUSY=1, counter=0.
- IDLE with REQ=0: the state holds and PTR is unchanged.
- GRANT → IDLE at a rising edge where any release condition holds:
  - DONE=1, or
  - REQ[GID]=0 (owner withdrew), or
  - timeout (see Configuration).
- On release:
  - GNT=0000, BUSY=0, PTR=GID+1 mod 4 (wraps 3→0).
  - GID keeps the last owner.
- GRANT with no release condition: grant and GID are stable, and the counter increments.
- Every release is followed by at least one IDLE cycle, a mandatory turnaround. GNT never switches directly between owners.
- Simultaneous events:
  - DONE together with timeout: treated as a normal release, TOUT stays 0.
  - Owner drop together with timeout: same, TOUT stays 0.
  - Requests from non-owners during GRANT are ignored until IDLE.
- REQ changes of non-owner bits never affect the current grant.
- GNT is at most one-hot in every cycle. It is never X after reset.

## Timing
- Grant latency:
  - A REQ high before edge N, with the block in IDLE, gives GNT high after edge N. That is one cycle.
- Release latency:
  - DONE high sampled at edge M gives GNT low after edge M.
  - The earliest next grant is after edge M+1.
- Back-to-back throughput: one grant per two cycles minimum, when each owner holds for exactly one cycle.
- TOUT is high for exactly the IDLE cycle following a forced release.
- All outputs are driven directly from flops, with no combinational path from input to output.
- Reset mid-GRANT: GNT drops immediately, asynchronously.
- Reset release: the first grant is possible at the first rising edge after RN deasserts. RN deassertion must meet recovery to CLK.

## Configuration
- Macro: GF180MCU_FD_SC_MCU7T5V0__RRARB4_TIMEOUT_EN.
- Defined:
  - An 8-bit hold counter is instantiated.
  - At the edge where the counter equals HOLD_MAX-1 in GRANT, with no DONE and no owner drop, the grant is revoked.
  - The revocation is normal release behaviour, PTR included, and TOUT=1 for the next cycle.
  - Maximum continuous GNT assertion is HOLD_MAX cycles.
- Undefined:
  - No counter is instantiated.
  - TOUT is tied to 0.
  - A grant is held indefinitely until DONE or owner drop.
  - HOLD_MAX is ignored.

## Test plan
- Reset/idle:
  - Stimulus: RN=0 mid-GRANT with GNT=0100.
  - Required response: GNT=0000, GID=00, BUSY=0 immediately, before any clock edge.
  - After RN=1 with REQ=0000: state stays IDLE for 10 cycles.
- Rotation:
  - Stimulus: REQ=1111 held, DONE pulsed one cycle after each grant.
  - Required response: grants issued in order 0001, 0010, 0100, 1000, 0001, each separated by one IDLE cycle.
- Wrap-around priority:
  - Stimulus: after master 3 releases, REQ=1001.
  - Required response: next grant is GNT=0001, GID=00.
- Owner drop and non-owner masking:
  - Stimulus: grant to master 1; toggle REQ[3] and REQ[0] for 5 cycles; then REQ[1]=0.
  - Required response: GNT stays 0010 throughout the toggling. After REQ[1]=0, GNT=0000 after that edge and PTR=2.
- Timeout (macro defined, HOLD_MAX=4):
  - Stimulus: master 2 holds REQ with no DONE.
  - Required response: GNT=0100 for exactly 4 cycles, then TOUT=1 for one cycle with GNT=0000.
  - Repeat with DONE on the 4th cycle: required response is TOUT=0.
- Macro undefined, same stimulus as the timeout scenario:
  - Required response: GNT=0100 for 300 cycles and TOUT=0 throughout.
